obuf_drain: RTL and testbench
=============================

# obuf_drain

Read-side controller for the ping-pong output buffers (o_buf0 / o_buf1) that the psum controller fills during output load. After an output load completes, this block reads the selected buffer sequentially, streams each word onto a valid/ready master stream toward the host/DMA path, and releases the buffer for the next tile. Reads are prefetched through a 2-entry skid FIFO so the stream sustains 1 word/cycle under continuous ready and loses no data under backpressure.

## Interface
- O_BRAM_ADDR_WIDTH, 7, output buffer address width (AW)
- O_BRAM_DATA_WIDTH, 32, output buffer / stream data width (DW)

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begin draining (honoured only in IDLE)
- o_sel  in  1  buffer to drain (0 = o_buf0, 1 = o_buf1), latched on start
- len  in  AW+1  words to drain, latched on start; 0 = empty transfer; values > 2^AW saturate to 2^AW
- o_buf0_en / o_buf1_en  out  1  read enable of each buffer port
- o_buf0_addr / o_buf1_addr  out  AW  read address
- o_buf0_dout / o_buf1_dout  in  DW  read data, valid the cycle after en
- m_tdata  out  DW  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  marks final word
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, transfer complete
- buf_release  out  1  one-cycle pulse with done; released buffer given by rel_sel
- rel_sel  out  1  latched o_sel of the finished transfer

## Operation
- States: IDLE, READ, FLUSH, FIN.
- IDLE: busy=0. On start: latch o_sel, len (saturated), clear rd_cnt, beat_cnt; go READ (or FIN if len=0).
- READ: issue read (en=1 on selected port only, addr=rd_cnt) when issued-but-unreturned (0 or 1) plus FIFO occupancy < 2; rd_cnt++ per issue. When rd_cnt reaches len after an issue -> FLUSH. Non-selected port en=0 always.
- Read return: data captured into FIFO on the edge after the en cycle (pending flag pipelined with en).
- Stream: m_tvalid = FIFO non-empty; m_tdata = FIFO head; pop when m_tvalid & m_tready; beat_cnt++ per pop; m_tlast = m_tvalid & (beat_cnt == len-1).
- FLUSH: no reads; exit to FIN when last beat pops.
- FIN: one cycle; done=1, buf_release=1, rel_sel valid; -> IDLE.
- Credit rule guarantees FIFO never overflows; simultaneous push and pop in the same cycle keeps occupancy.
- start while busy: ignored, no effect on latched o_sel/len.
- m_tvalid, once high, stays high with m_tdata stable until accepted.
- Addresses never wrap: max address 2^AW-1 for saturated len.

## Timing
- Reset values: all en=0, addr=0, m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, done=0, buf_release=0, rel_sel=0; FIFO empty, state IDLE.
- Reset mid-transfer: next cycle all outputs at reset values, in-flight read data discarded, no done pulse.
- start sampled cycle T: busy=1 and first en at T+1 (addr 0); data captured T+2; m_tvalid=1 from T+3.
- Continuous ready: one beat per cycle, last beat at T+2+len; done at T+3+len.
- len=0: FIN at T+1, done at T+1, no en, no stream beats.
- Ready low for k cycles: read issue stalls after FIFO full + pending fills (≤2 words buffered), resumes the cycle after ready returns; no beat lost or duplicated.

## Test plan
- Reset then o_sel=0, len=8, m_tready=1, o_buf0[i]=i+0x100 -> o_buf0_en at T+1..T+8 addr 0..7, o_buf1_en never high, beats 0x100..0x107 at T+3..T+10, m_tlast on 0x107, done/buf_release at T+11 with rel_sel=0.
- o_sel=1, len=128 (full buffer), ready toggling 1-0 every cycle -> 128 beats in order, addr 127 max, no wrap, rel_sel=1, m_tdata stable while valid & !ready.
- len=0 start -> done at T+1, m_tvalid never high, no en.
- len=16, ready held low 10 cycles after first valid -> at most 2 reads issued beyond popped beats while stalled; after release all 16 words in order, exactly one m_tlast.
- Second start pulse mid-transfer with o_sel flipped and len=3 -> ignored; original transfer completes with original len and rel_sel.
- rstn low at beat 5 of len=32 -> next cycle all outputs zero, no done; fresh start len=4 drains correctly from addr 0.

Source files
------------

// File: rtl/obuf_drain.sv
// obuf_drain: read-side controller for the ping-pong output buffers.
// After an output load completes, this block reads the selected buffer
// (o_buf0 or o_buf1) from address 0 upward and streams each word out on a
// valid/ready master stream. When the transfer is complete it pulses
// done/buf_release so the buffer can be refilled for the next tile. Reads
// are prefetched into a 2-entry skid FIFO. This lets the stream run at one
// word per cycle under continuous ready without losing data under
// backpressure.
//
// Ports:
//   clk, rstn                 clock (rising edge), synchronous active-low reset
//   start, o_sel, len         start pulse; buffer select and word count,
//                             both latched on an accepted start
//   o_bufN_en / o_bufN_addr   read port of each buffer (only the selected one
//                             is ever enabled)
//   o_bufN_dout               read data, valid the cycle after en
//   m_tdata/m_tvalid/m_tready/m_tlast   output stream
//   busy                      transfer in progress
//   done, buf_release         one-cycle completion pulse
//   rel_sel                   buffer that the finished transfer used
module obuf_drain #(
  parameter int O_BRAM_ADDR_WIDTH = 7,
  parameter int O_BRAM_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         o_sel,
  input  logic [O_BRAM_ADDR_WIDTH:0]   len,
  output logic                         o_buf0_en,
  output logic                         o_buf1_en,
  output logic [O_BRAM_ADDR_WIDTH-1:0] o_buf0_addr,
  output logic [O_BRAM_ADDR_WIDTH-1:0] o_buf1_addr,
  input  logic [O_BRAM_DATA_WIDTH-1:0] o_buf0_dout,
  input  logic [O_BRAM_DATA_WIDTH-1:0] o_buf1_dout,
  output logic [O_BRAM_DATA_WIDTH-1:0] m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic                         busy,
  output logic                         done,
  output logic                         buf_release,
  output logic                         rel_sel
);

  localparam int AW = O_BRAM_ADDR_WIDTH;
  localparam int DW = O_BRAM_DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  // A transfer can never be longer than the buffer, so addresses cannot wrap.
  function automatic logic [AW:0] sat_len(input logic [AW:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  logic [1:0]    state;
  logic          sel_r;
  logic [AW:0]   len_r;
  logic [AW:0]   rd_cnt;
  logic [AW:0]   beat_cnt;
  logic          rd_vld_p1;
  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_cnt;

  logic          pop;
  logic          issue;
  logic          last_beat;
  logic [1:0]    occ_after;
  logic [AW:0]   rd_cnt_nxt;
  logic [DW-1:0] push_data;

  assign m_tvalid   = (fifo_cnt != 2'd0);
  assign pop        = m_tvalid & m_tready;
  // Count the pop in this cycle toward the available credit. Without it, a
  // 2-entry FIFO with 1-cycle read latency could not sustain one word per
  // cycle. Pending plus occupancy stays <= 2 on the next cycle either way.
  assign occ_after  = fifo_cnt - {1'b0, pop};
  assign issue      = (state == S_READ) && (({1'b0, rd_vld_p1} + occ_after) < 2'd2);
  assign rd_cnt_nxt = rd_cnt + ONE;
  assign last_beat  = (beat_cnt == (len_r - ONE));

  assign m_tlast     = m_tvalid & last_beat;
  assign m_tdata     = m_tvalid ? fifo_mem[rd_ptr] : '0;
  assign o_buf0_en   = issue & ~sel_r;
  assign o_buf1_en   = issue & sel_r;
  assign o_buf0_addr = o_buf0_en ? rd_cnt[AW-1:0] : '0;
  assign o_buf1_addr = o_buf1_en ? rd_cnt[AW-1:0] : '0;
  assign push_data   = sel_r ? o_buf1_dout : o_buf0_dout;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign buf_release = (state == S_FIN);
  assign rel_sel     = sel_r;

  // Stage p0 -> p1: read issued; the return is valid when rd_vld_p1 is high
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      sel_r     <= 1'b0;
      len_r     <= '0;
      rd_cnt    <= '0;
      beat_cnt  <= '0;
      rd_vld_p1 <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      rd_vld_p1 <= issue;
      if (rd_vld_p1) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= beat_cnt + ONE;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, pop};

      case (state)
        S_IDLE: begin
          if (start) begin
            sel_r    <= o_sel;
            len_r    <= sat_len(len);
            rd_cnt   <= '0;
            beat_cnt <= '0;
            state    <= (len == '0) ? S_FIN : S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            rd_cnt <= rd_cnt_nxt;
            if (rd_cnt_nxt == len_r) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (pop && last_beat) state <= S_FIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1 -> FIFO: capture returned read data (storage needs no reset)
  always_ff @(posedge clk) begin
    if (rd_vld_p1) fifo_mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_obuf_drain.sv
module tb_obuf_drain;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          o_sel;
  logic [AW:0]   len;
  logic          o_buf0_en, o_buf1_en;
  logic [AW-1:0] o_buf0_addr, o_buf1_addr;
  logic [DW-1:0] o_buf0_dout, o_buf1_dout;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic          busy, done, buf_release, rel_sel;

  logic [DW-1:0] mem0 [128];
  logic [DW-1:0] mem1 [128];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // monitor records
  logic [DW-1:0] bq_data[$];
  int            bq_cyc[$];
  bit            bq_last[$];
  int            en_cyc[$];
  int            en_addr[$];
  int            done_cyc[$];
  bit            done_rel[$];
  int en0_n, en1_n, en_total, pop_total, max_out, stab_bad, both_bad, rel_bad;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  obuf_drain #(.O_BRAM_ADDR_WIDTH(AW), .O_BRAM_DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .o_sel(o_sel), .len(len),
    .o_buf0_en(o_buf0_en), .o_buf1_en(o_buf1_en),
    .o_buf0_addr(o_buf0_addr), .o_buf1_addr(o_buf1_addr),
    .o_buf0_dout(o_buf0_dout), .o_buf1_dout(o_buf1_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .buf_release(buf_release), .rel_sel(rel_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: synchronous read, data valid the cycle after en
  always @(posedge clk) begin
    if (o_buf0_en) o_buf0_dout <= mem0[o_buf0_addr];
    if (o_buf1_en) o_buf1_dout <= mem1[o_buf1_addr];
  end

  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) prev_stall = 1'b0;
      else begin
        if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) stab_bad++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
      if (o_buf0_en) en0_n++;
      if (o_buf1_en) en1_n++;
      if (o_buf0_en && o_buf1_en) both_bad++;
      if (o_buf0_en || o_buf1_en) begin
        en_total++;
        en_cyc.push_back(cyc);
        en_addr.push_back(o_buf0_en ? int'(o_buf0_addr) : int'(o_buf1_addr));
      end
      if (m_tvalid && m_tready) begin
        bq_data.push_back(m_tdata);
        bq_cyc.push_back(cyc);
        bq_last.push_back(m_tlast);
        pop_total++;
      end
      if (en_total - pop_total > max_out) max_out = en_total - pop_total;
      if (done) begin
        done_cyc.push_back(cyc);
        done_rel.push_back(rel_sel);
        if (!buf_release) rel_bad++;
      end
      if (buf_release && !done) rel_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bq_data.delete(); bq_cyc.delete(); bq_last.delete();
    en_cyc.delete(); en_addr.delete(); done_cyc.delete(); done_rel.delete();
    en0_n = 0; en1_n = 0; en_total = 0; pop_total = 0; max_out = 0;
    stab_bad = 0; both_bad = 0; rel_bad = 0;
  endtask

  function automatic logic [DW-1:0] exp_word(input logic sel, input int i);
    return sel ? mem1[i] : mem0[i];
  endfunction

  function automatic logic [63:0] out_vec();
    return {10'd0, o_buf0_en, o_buf1_en, o_buf0_addr, o_buf1_addr, m_tvalid,
            m_tdata, m_tlast, busy, done, buf_release, rel_sel};
  endfunction

  task automatic fill(input bit inc);
    for (int i = 0; i < 128; i++) begin
      mem0[i] = inc ? (32'h100 + i) : $urandom;
      mem1[i] = inc ? (32'h200 + i) : $urandom;
    end
  endtask

  // mode 0: ready always high; 1: ready toggles; 2: ready low until 10 cycles
  // after first valid; 3: ready high with a stray start mid-transfer
  task automatic run_xfer(input logic sel, input logic [AW:0] l, input int mode);
    int n, t0, budget, stall, errs, lastn;
    bit seen_valid;
    n = (int'(l) > 128) ? 128 : int'(l);
    clear_mon();
    @(posedge clk); #1;
    o_sel = sel; len = l; start = 1'b1; t0 = cyc;
    m_tready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0; o_sel = ~sel; len = AW'($urandom);
    chk("busy_after_start", busy, 1'b1);
    budget = 4 * n + 100; stall = 0; seen_valid = 0;
    while (done_cyc.size() == 0 && budget > 0) begin
      case (mode)
        1: m_tready = ~m_tready;
        2: begin
          if (m_tvalid) seen_valid = 1;
          if (seen_valid && !m_tready) begin
            if (stall == 10) begin
              chk("stall_issued", en_total, 2);
              chk("stall_popped", pop_total, 0);
              m_tready = 1'b1;
            end
            stall++;
          end
        end
        3: begin
          if (cyc == t0 + 5) begin start = 1'b1; o_sel = ~sel; len = 3; end
          else start = 1'b0;
        end
        default: m_tready = 1'b1;
      endcase
      @(posedge clk); #1;
      budget--;
    end
    start = 1'b0;
    chk("no_timeout", budget > 0, 1'b1);
    chk("idle_after_done", busy, 1'b0);
    chk("beat_count", bq_data.size(), n);
    errs = 0; lastn = 0;
    for (int i = 0; i < bq_data.size() && i < n; i++)
      if (bq_data[i] !== exp_word(sel, i)) errs++;
    for (int i = 0; i < bq_last.size(); i++) if (bq_last[i]) lastn++;
    chk("data_order", errs, 0);
    chk("tlast_count", lastn, (n == 0) ? 0 : 1);
    if (n > 0 && bq_last.size() == n) chk("tlast_pos", bq_last[n-1], 1'b1);
    chk("unsel_en", sel ? en0_n : en1_n, 0);
    chk("sel_en", sel ? en1_n : en0_n, n);
    errs = 0;
    for (int i = 0; i < en_addr.size(); i++) if (en_addr[i] != i) errs++;
    chk("addr_seq", errs, 0);
    chk("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk("rel_sel", done_rel[0], sel);
      if (mode == 0) chk("done_cyc", done_cyc[0] - t0, n + 3 - ((n == 0) ? 2 : 0));
    end
    chk("tdata_stable", stab_bad, 0);
    chk("outstanding_le2", max_out <= 2, 1'b1);
    chk("release_with_done", rel_bad + both_bad, 0);
    if (mode == 0 && n > 0 && bq_cyc.size() == n && en_cyc.size() == n) begin
      chk("first_beat_cyc", bq_cyc[0] - t0, 3);
      chk("last_beat_cyc", bq_cyc[n-1] - t0, n + 2);
      errs = 0;
      for (int i = 0; i < n; i++) if (en_cyc[i] != t0 + 1 + i) errs++;
      chk("en_timing", errs, 0);
    end
  endtask

  initial begin
    int budget;
    rstn = 1'b0; start = 1'b0; o_sel = 1'b0; len = '0; m_tready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), 64'd0);
    rstn = 1'b1;

    fill(1);
    run_xfer(1'b0, 8, 0);
    fill(0);
    run_xfer(1'b1, 128, 1);
    run_xfer(1'b0, 0, 0);
    fill(0);
    run_xfer(1'b1, 16, 2);
    fill(0);
    run_xfer(1'b0, 20, 3);
    fill(0);
    run_xfer(1'b1, 200, 0);

    // reset in the middle of a transfer
    fill(0);
    clear_mon();
    @(posedge clk); #1;
    o_sel = 1'b1; len = 32; start = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 200;
    while (bq_data.size() < 5 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("reach_beat5", budget > 0, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midreset_outputs", out_vec(), 64'd0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cyc.size(), 0);
    chk("midreset_idle", out_vec(), 64'd0);
    fill(0);
    run_xfer(1'b0, 4, 0);

    for (int k = 0; k < 4; k++) begin
      fill(0);
      run_xfer(1'($urandom), AW'($urandom_range(1, 127)) , int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
